// File: rtl/unidad_busqueda.sv
// Instruction fetch unit: loadable memory + PC, streams words in order over valid/ready.
// First word valid two edges after inicio; a two-entry buffer absorbs back-pressure at full throughput.
module unidad_busqueda #(
   parameter int          PROFUNDIDAD = 32,
   parameter int          DIR_W       = 5,
   parameter logic [5:0]  OP_ALTO     = 6'b111111
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             carga_en,
   input  logic [DIR_W-1:0] carga_dir,
   input  logic [31:0]      carga_dato,
   input  logic             inicio,
   input  logic             instr_ready,
   output logic [31:0]      instruccion_r,
   output logic             instr_valid,
   output logic [DIR_W-1:0] pc,
   output logic             ocupado,
   output logic             terminado
);

   localparam logic [1:0] INACTIVO = 2'd0;
   localparam logic [1:0] BUSCANDO = 2'd1;
   localparam logic [1:0] DETENIDO = 2'd2;

   localparam logic [DIR_W-1:0] ULTIMA = DIR_W'(PROFUNDIDAD - 1);
   localparam logic [DIR_W-1:0] UNO    = DIR_W'(1);

   logic [31:0]      mem [PROFUNDIDAD];

   logic [1:0]       estado;
   logic [DIR_W-1:0] rd_ptr;
   logic             alto;
   logic             fin_mem;

   logic [31:0]      rd_dato;
   logic [DIR_W-1:0] rd_pc;
   logic             en_vuelo;

   logic [31:0]      out_dat;
   logic [DIR_W-1:0] out_pc;
   logic             out_vld;
   logic [31:0]      sk_dat;
   logic [DIR_W-1:0] sk_pc;
   logic             sk_vld;

   logic             salida;
   logic             alto_vuelo;
   logic             llega;
   logic [1:0]       carga;
   logic             emitir;
   logic             escribir;

   always_comb begin
      salida     = out_vld && instr_ready;
      alto_vuelo = en_vuelo && (rd_dato[31:26] == OP_ALTO);
      llega      = en_vuelo && !alto_vuelo;
      // Slots committed next cycle: held words plus the read in flight, minus the one leaving now.
      carga      = {1'b0, out_vld} + {1'b0, sk_vld} + {1'b0, en_vuelo} - {1'b0, salida};
      emitir     = (estado == BUSCANDO) && !alto && !alto_vuelo && !fin_mem && (carga < 2'd2);
      escribir   = carga_en && !rst && (estado != BUSCANDO);
   end

   always_ff @(posedge clk) begin
      if (escribir) begin
         mem[carga_dir] <= carga_dato;
      end
      if (emitir) begin
         rd_dato <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado   <= INACTIVO;
         rd_ptr   <= '0;
         alto     <= 1'b0;
         fin_mem  <= 1'b0;
         rd_pc    <= '0;
         en_vuelo <= 1'b0;
         out_dat  <= '0;
         out_pc   <= '0;
         out_vld  <= 1'b0;
         sk_dat   <= '0;
         sk_pc    <= '0;
         sk_vld   <= 1'b0;
      end else begin
         case (estado)
            BUSCANDO: begin
               en_vuelo <= emitir;
               if (emitir) begin
                  rd_pc  <= rd_ptr;
                  rd_ptr <= rd_ptr + UNO;
                  if (rd_ptr == ULTIMA) begin
                     fin_mem <= 1'b1;
                  end
               end
               if (alto_vuelo) begin
                  alto <= 1'b1;
               end

               if (salida) begin
                  if (sk_vld) begin
                     out_dat <= sk_dat;
                     out_pc  <= sk_pc;
                     out_vld <= 1'b1;
                     sk_vld  <= llega;
                     if (llega) begin
                        sk_dat <= rd_dato;
                        sk_pc  <= rd_pc;
                     end
                  end else begin
                     out_vld <= llega;
                     if (llega) begin
                        out_dat <= rd_dato;
                        out_pc  <= rd_pc;
                     end
                  end
               end else if (!out_vld) begin
                  out_vld <= llega;
                  if (llega) begin
                     out_dat <= rd_dato;
                     out_pc  <= rd_pc;
                  end
               end else if (llega) begin
                  sk_vld <= 1'b1;
                  sk_dat <= rd_dato;
                  sk_pc  <= rd_pc;
               end

               if ((alto || fin_mem) && !out_vld && !sk_vld && !en_vuelo) begin
                  estado <= DETENIDO;
               end
            end
            default: begin
               if (inicio) begin
                  estado   <= BUSCANDO;
                  rd_ptr   <= '0;
                  alto     <= 1'b0;
                  fin_mem  <= 1'b0;
                  en_vuelo <= 1'b0;
                  out_vld  <= 1'b0;
                  sk_vld   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign instruccion_r = out_dat;
   assign instr_valid   = out_vld;
   assign pc            = out_pc;
   assign ocupado       = (estado == BUSCANDO);
   assign terminado     = (estado == DETENIDO);

endmodule

// File: tb/tb_unidad_busqueda.sv
// Directed bench for unidad_busqueda: per-cycle vector tables plus a hand-written reset-mid-fetch sequence.
module tb_unidad_busqueda;

   localparam int PROF = 4;
   localparam int DW   = 2;

   localparam logic [31:0] W0   = 32'h00221820;
   localparam logic [31:0] W1   = 32'h00853022;
   localparam logic [31:0] W2   = 32'h00C73824;
   localparam logic [31:0] HALT = 32'hFC000000;
   localparam logic [31:0] DB   = 32'hDEADBEEF;

   logic          clk = 1'b0;
   logic          rst;
   logic          carga_en;
   logic [DW-1:0] carga_dir;
   logic [31:0]   carga_dato;
   logic          inicio;
   logic          instr_ready;
   logic [31:0]   instruccion_r;
   logic          instr_valid;
   logic [DW-1:0] pc;
   logic          ocupado;
   logic          terminado;

   int n_chk = 0;
   int n_ok  = 0;

   unidad_busqueda #(
      .PROFUNDIDAD(PROF),
      .DIR_W      (DW),
      .OP_ALTO    (6'b111111)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .carga_en     (carga_en),
      .carga_dir    (carga_dir),
      .carga_dato   (carga_dato),
      .inicio       (inicio),
      .instr_ready  (instr_ready),
      .instruccion_r(instruccion_r),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .ocupado      (ocupado),
      .terminado    (terminado)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          ini;
      logic          rdy;
      logic          we;
      logic [DW-1:0] wa;
      logic [31:0]   wd;
      logic          vld;
      logic [31:0]   dat;
      logic [DW-1:0] pcx;
      logic          ocu;
      logic          ter;
   } vec_t;

   vec_t tabla[$];

   function automatic void v(input logic ini, input logic rdy, input logic we,
                             input logic [DW-1:0] wa, input logic [31:0] wd,
                             input logic vld, input logic [31:0] dat, input logic [DW-1:0] p,
                             input logic ocu, input logic ter);
      vec_t e;
      e.ini = ini; e.rdy = rdy; e.we = we; e.wa = wa; e.wd = wd;
      e.vld = vld; e.dat = dat; e.pcx = p; e.ocu = ocu; e.ter = ter;
      tabla.push_back(e);
   endfunction

   task automatic chk(input string nom, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_ok++;
      else $display("FAIL %s: got %h expected %h", nom, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inicio = 1'b0; instr_ready = 1'b0; carga_en = 1'b0; carga_dir = '0; carga_dato = '0;
   endtask

   task automatic chk_todo(input string tag, input logic vld, input logic [31:0] dat,
                           input logic [DW-1:0] p, input logic ocu, input logic ter);
      chk({tag, " valid"},     {31'b0, instr_valid}, {31'b0, vld});
      chk({tag, " instr"},     instruccion_r, dat);
      chk({tag, " pc"},        {30'b0, pc}, {30'b0, p});
      chk({tag, " ocupado"},   {31'b0, ocupado}, {31'b0, ocu});
      chk({tag, " terminado"}, {31'b0, terminado}, {31'b0, ter});
   endtask

   task automatic run_tabla(input string tag);
      for (int i = 0; i < tabla.size(); i++) begin
         inicio      = tabla[i].ini;
         instr_ready = tabla[i].rdy;
         carga_en    = tabla[i].we;
         carga_dir   = tabla[i].wa;
         carga_dato  = tabla[i].wd;
         tick();
         chk($sformatf("%s[%0d] valid", tag, i),     {31'b0, instr_valid}, {31'b0, tabla[i].vld});
         chk($sformatf("%s[%0d] ocupado", tag, i),   {31'b0, ocupado},     {31'b0, tabla[i].ocu});
         chk($sformatf("%s[%0d] terminado", tag, i), {31'b0, terminado},   {31'b0, tabla[i].ter});
         if (tabla[i].vld) begin
            chk($sformatf("%s[%0d] instr", tag, i), instruccion_r, tabla[i].dat);
            chk($sformatf("%s[%0d] pc", tag, i),    {30'b0, pc},   {30'b0, tabla[i].pcx});
         end
      end
      tabla.delete();
      idle();
   endtask

   initial begin
      logic [31:0] prog [4];
      prog[0] = W0; prog[1] = W1; prog[2] = W2; prog[3] = HALT;

      idle();
      rst = 1'b1;
      tick();
      chk_todo("reset", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         carga_en = 1'b1; carga_dir = DW'(i); carga_dato = prog[i];
         tick();
      end
      idle();

      // Basic stream from INACTIVO; halt word at address 3 is never presented.
      v(1,1,0,0,0, 0,0, 0, 1,0);
      v(0,1,0,0,0, 0,0, 0, 1,0);
      v(0,1,0,0,0, 1,W0,0, 1,0);
      v(0,1,0,0,0, 1,W1,1, 1,0);
      v(0,1,0,0,0, 1,W2,2, 1,0);
      v(0,1,0,0,0, 0,0, 0, 1,0);
      v(0,1,0,0,0, 0,0, 0, 0,1);
      run_tabla("basic");

      // Restart from DETENIDO with back-pressure; inicio at [4] lands in BUSCANDO and is ignored.
      v(1,1,0,0,0, 0,0, 0, 1,0);
      v(0,1,0,0,0, 0,0, 0, 1,0);
      v(0,1,0,0,0, 1,W0,0, 1,0);
      v(0,1,0,0,0, 1,W1,1, 1,0);
      v(1,0,0,0,0, 1,W1,1, 1,0);
      v(0,0,0,0,0, 1,W1,1, 1,0);
      v(0,0,0,0,0, 1,W1,1, 1,0);
      v(0,0,0,0,0, 1,W1,1, 1,0);
      v(0,1,0,0,0, 1,W2,2, 1,0);
      v(0,1,0,0,0, 0,0, 0, 1,0);
      v(0,1,0,0,0, 0,0, 0, 0,1);
      run_tabla("bpress");

      // Reload without halt, end-of-memory stop, and write gating in BUSCANDO vs DETENIDO.
      v(0,0,1,0,1,   0,0,0, 0,1);
      v(0,0,1,1,2,   0,0,0, 0,1);
      v(0,0,1,2,3,   0,0,0, 0,1);
      v(0,0,1,3,4,   0,0,0, 0,1);
      v(1,1,0,0,0,   0,0,0, 1,0);
      v(0,1,1,1,DB,  0,0,0, 1,0);
      v(0,1,0,0,0,   1,1,0, 1,0);
      v(0,1,0,0,0,   1,2,1, 1,0);
      v(0,1,0,0,0,   1,3,2, 1,0);
      v(0,1,0,0,0,   1,4,3, 1,0);
      v(0,1,0,0,0,   0,0,0, 1,0);
      v(0,1,0,0,0,   0,0,0, 0,1);
      v(1,1,1,1,DB,  0,0,0, 1,0);
      v(0,1,0,0,0,   0,0,0, 1,0);
      v(0,1,0,0,0,   1,1,0, 1,0);
      v(0,1,0,0,0,   1,DB,1,1,0);
      v(0,1,0,0,0,   1,3,2, 1,0);
      v(0,1,0,0,0,   1,4,3, 1,0);
      v(0,1,0,0,0,   0,0,0, 1,0);
      v(0,1,0,0,0,   0,0,0, 0,1);
      run_tabla("endmem");

      // Reset while a word is stalled on the output.
      inicio = 1'b1; instr_ready = 1'b0;
      tick();
      inicio = 1'b0;
      tick();
      tick();
      chk_todo("stall0", 1'b1, 32'h1, 2'd0, 1'b1, 1'b0);
      tick();
      chk_todo("stall1", 1'b1, 32'h1, 2'd0, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_todo("rst_mid", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
      instr_ready = 1'b1;
      tick();
      tick();
      chk({"post_rst valid"},   {31'b0, instr_valid}, 32'h0);
      chk({"post_rst ocupado"}, {31'b0, ocupado},     32'h0);
      inicio = 1'b1;
      tick();
      inicio = 1'b0;
      tick();
      tick();
      chk_todo("rerun0", 1'b1, 32'h1, 2'd0, 1'b1, 1'b0);
      tick();
      chk_todo("rerun1", 1'b1, DB, 2'd1, 1'b1, 1'b0);
      idle();

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
